// File: rtl/rx_lane_sync_ctrl_pkg.sv
// Shared definitions for the two-lane receive synchroniser: state encodings,
// byte classification and a saturating counter helper.
package rx_lane_sync_ctrl_pkg;

  // Idle/comma byte transmitted while a lane's valid is low.
  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

  // Width of every cnt/err/tmo counter in the block.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    LANE_HUNT   = 2'd0,
    LANE_CHECK  = 2'd1,
    LANE_LOCKED = 2'd2
  } lane_state_e;

  typedef enum logic [1:0] {
    LINK_DOWN  = 2'd0,
    LINK_ALIGN = 2'd1,
    LINK_UP    = 2'd2
  } link_state_e;

  typedef enum logic [1:0] {
    BYTE_COMMA = 2'd0,
    BYTE_GOOD  = 2'd1,
    BYTE_BAD   = 2'd2
  } byte_class_e;

  // A byte with valid high is payload whatever its value; otherwise it must
  // be the comma to count as idle, anything else is a line error.
  function automatic byte_class_e classify(input logic valid,
                                           input logic [7:0] data,
                                           input logic [7:0] comma);
    byte_class_e cls;
    if (valid) begin
      cls = BYTE_GOOD;
    end else if (data == comma) begin
      cls = BYTE_COMMA;
    end else begin
      cls = BYTE_BAD;
    end
    return cls;
  endfunction

  // Counters stop at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_lane_sync_ctrl_lane_lock.sv
// Per-lane comma lock FSM: hunts for LOCK_CNT consecutive commas, then stays
// locked until LOSS_CNT consecutive bad bytes are seen.
module rx_lane_lock
  import rx_lane_sync_ctrl_pkg::*;
#(
  parameter logic [7:0]  COMMA    = COMMA_DEFAULT,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_stb,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       lock,
  output logic       comma_hit,
  output logic       lock_drop
);

  localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] LOSS_TGT = CNT_W'(LOSS_CNT);

  lane_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             lock_q, lock_d;

  byte_class_e      cls;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] err_inc;

  assign cls     = classify(valid, data, COMMA);
  assign cnt_inc = sat_inc(cnt_q);
  assign err_inc = sat_inc(err_q);

  // Comma seen on this strobe; the link FSM needs it to detect alignment.
  assign comma_hit = byte_stb && (cls == BYTE_COMMA);

  // Next-state and counter update; nothing moves between byte strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    lock_drop = 1'b0;
    if (byte_stb) begin
      case (state_q)
        LANE_HUNT: begin
          if (cls == BYTE_COMMA) begin
            state_d = LANE_CHECK;
            cnt_d   = 4'd1;
          end
        end
        LANE_CHECK: begin
          if (cls == BYTE_COMMA) begin
            cnt_d = cnt_inc;
            if (cnt_inc == LOCK_TGT) begin
              state_d = LANE_LOCKED;
              err_d   = '0;
            end
          end else begin
            // Any non-comma breaks the run; the next lock starts from scratch.
            state_d = LANE_HUNT;
            cnt_d   = '0;
          end
        end
        LANE_LOCKED: begin
          if (cls == BYTE_BAD) begin
            err_d = err_inc;
            if (err_inc == LOSS_TGT) begin
              state_d   = LANE_HUNT;
              cnt_d     = '0;
              err_d     = '0;
              lock_drop = 1'b1;
            end
          end else begin
            err_d = '0;
          end
        end
        default: begin
          state_d = LANE_HUNT;
          cnt_d   = '0;
          err_d   = '0;
        end
      endcase
    end
  end

  // The lock flag is registered alongside the state it mirrors.
  always_comb begin
    lock_d = (state_d == LANE_LOCKED);
  end

  // Lane state, counters and lock output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LANE_HUNT;
      cnt_q   <= '0;
      err_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      lock_q  <= lock_d;
    end
  end

  assign lock = lock_q;

endmodule

// File: rtl/rx_lane_sync_ctrl.sv
// Two-lane receive sequencer: locks each lane on the idle comma, then waits
// for both lanes to show a comma on the same strobe before enabling the
// downstream 8->32 converters and unstriper.
module rx_lane_sync_ctrl
  import rx_lane_sync_ctrl_pkg::*;
#(
  parameter logic [7:0]  COMMA     = COMMA_DEFAULT,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned LOSS_CNT  = 3,
  parameter int unsigned ALIGN_TMO = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_stb,
  input  logic [7:0] lane0_data,
  input  logic       lane0_valid,
  input  logic [7:0] lane1_data,
  input  logic       lane1_valid,
  output logic       lane0_lock,
  output logic       lane1_lock,
  output logic       link_up,
  output logic       rx_enable,
  output logic       align_fail
);

  localparam logic [CNT_W-1:0] TMO_TGT = CNT_W'(ALIGN_TMO);

  logic [1:0][7:0] lane_data;
  logic [1:0]      lane_valid;
  logic [1:0]      lane_lock;
  logic [1:0]      lane_comma;
  logic [1:0]      lane_drop;

  assign lane_data[0]  = lane0_data;
  assign lane_data[1]  = lane1_data;
  assign lane_valid[0] = lane0_valid;
  assign lane_valid[1] = lane1_valid;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    rx_lane_lock #(
      .COMMA    (COMMA),
      .LOCK_CNT (LOCK_CNT),
      .LOSS_CNT (LOSS_CNT)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .byte_stb  (byte_stb),
      .data      (lane_data[gi]),
      .valid     (lane_valid[gi]),
      .lock      (lane_lock[gi]),
      .comma_hit (lane_comma[gi]),
      .lock_drop (lane_drop[gi])
    );
  end

  link_state_e      link_q, link_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             link_up_q, link_up_d;
  logic             align_fail_q, align_fail_d;

  logic             both_locked;
  logic             both_comma;
  logic             any_drop;
  logic [CNT_W-1:0] tmo_inc;

  // Lane lock flags are the registered values, i.e. the state before this edge.
  assign both_locked = &lane_lock;
  assign both_comma  = &lane_comma;
  assign any_drop    = |lane_drop;
  assign tmo_inc     = sat_inc(tmo_q);

  // Link FSM: DOWN -> ALIGN -> UP, with the ALIGN window bounded by the timer.
  always_comb begin
    link_d       = link_q;
    tmo_d        = tmo_q;
    align_fail_d = 1'b0;
    case (link_q)
      LINK_DOWN: begin
        if (byte_stb && both_locked) begin
          tmo_d = '0;
          // The strobe that finds both lanes locked is also the first ALIGN
          // opportunity, so a coincident comma here already aligns the link.
          if (both_comma) begin
            link_d = LINK_UP;
          end else begin
            link_d = LINK_ALIGN;
          end
        end
      end
      LINK_ALIGN: begin
        if (byte_stb) begin
          if (!both_locked || any_drop) begin
            // Losing a lane takes priority over alignment and timeout alike.
            link_d = LINK_DOWN;
            tmo_d  = '0;
          end else if (both_comma) begin
            link_d = LINK_UP;
            tmo_d  = '0;
          end else begin
            tmo_d = tmo_inc;
            if (tmo_inc == TMO_TGT) begin
              link_d       = LINK_DOWN;
              tmo_d        = '0;
              align_fail_d = 1'b1;
            end
          end
        end
      end
      LINK_UP: begin
        // Checked every clock so payload is gated as soon as a lock falls.
        if (!both_locked) begin
          link_d = LINK_DOWN;
          tmo_d  = '0;
        end
      end
      default: begin
        link_d = LINK_DOWN;
        tmo_d  = '0;
      end
    endcase
  end

  // Output decode, registered with the state.
  always_comb begin
    link_up_d = (link_d == LINK_UP);
  end

  // Link state, align timer and registered link outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link_q       <= LINK_DOWN;
      tmo_q        <= '0;
      link_up_q    <= 1'b0;
      align_fail_q <= 1'b0;
    end else begin
      link_q       <= link_d;
      tmo_q        <= tmo_d;
      link_up_q    <= link_up_d;
      align_fail_q <= align_fail_d;
    end
  end

  assign lane0_lock = lane_lock[0];
  assign lane1_lock = lane_lock[1];
  assign link_up    = link_up_q;
  assign rx_enable  = link_up_q;
  assign align_fail = align_fail_q;

endmodule
